decade_counter_up: RTL
======================

# decade_counter_up

Multi-digit BCD decade up counter: the counting-up counterpart of the team's decade down counter. It is built as a ripple-free chain of single-decade cells. It supports synchronous parallel load, a count enable and a cascade carry output, and it keeps a sticky overflow flag. It serves as the event and tally counter in the display and timing datapaths, alongside the down counter.

## Interface
- DIGITS, 4: number of BCD decades; must be ≥1.
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; increments by one when high.
- load  in  1  synchronous parallel load; overrides en.
- load_val  in  4*DIGITS  BCD value to load; digit k is at [4k+3:4k].
- out  out  4*DIGITS  current count in BCD; digit 0 is least significant.
- tc  out  1  terminal count; combinational; high when every digit equals 9.
- carry_out  out  1  combinational; en & tc & ~load; used to cascade a further counter instance.
- ovf  out  1  sticky overflow flag; registered.

## Operation
- Reset (reset = 0, asynchronous) sets out = 0 and ovf = 0 immediately, independent of clk. Deassertion takes effect on the next falling edge.
- Priority on each falling edge: reset, then load, then en, then hold.
- Load: out <= load_val and ovf <= 0.
- Increment:
  - Digit 0 always steps when en = 1.
  - Digit k steps when en = 1 and digits 0..k-1 all equal 9.
  - A stepping digit goes from 9 to 0; otherwise it goes to d+1.
- Wrap: an increment from all-9s gives all-0s and sets ovf = 1. ovf then holds until load or reset.
- Illegal BCD digits (10–15), which can only enter through load, are treated as follows:
  - A stepping digit with a value >9 goes to 0. This is the same recovery rule as the down counter's self-correction.
  - An illegal digit does not count as 9 for carry or tc purposes.
- When en = 0 and load = 0, out and ovf hold.
- tc and carry_out are pure functions of the current out, en and load. They have no registered delay.

## Timing
- Single clock domain. Every registered output changes only on the falling edge of clk or on assertion of reset.
- Latency from en or load to out is one falling edge.
- carry_out is valid during the same cycle as the all-9s state, so a cascaded instance increments on that same falling edge.
- If load and en are both high at the wrap point, load wins: out = load_val, ovf = 0, and carry_out = 0.
- If reset is asserted in the middle of a cycle, out goes to 0 at once, regardless of any pending load or en.

## Configuration
- DECADE_UP_SAT_EN:
  - Defined: the counter saturates. When all digits are 9 and en = 1, out holds at all-9s, ovf sets to 1, and carry_out is forced to 0.
  - Undefined (default): wrap-around behaviour as described under Operation, with carry_out active.
- The macro has no effect on load, reset or tc.

## Structure
- Shared package decade_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - a function is_bcd_max(digit)
- Sub-module bcd_digit_up is one decade cell:
  - Inputs: clk, reset, step, load, ld_digit.
  - Outputs: digit, is9.
- The top level generates DIGITS instances. It forms each step signal as en & AND(is9 of all lower digits), and holds the ovf register and the tc/carry_out logic.

## Test plan
- Reset and load: hold reset = 0, then release it; load 16'h0000 with en = 1 for 12 edges → out = 16'h0012 and ovf = 0.
- Carry across digits: load 16'h0099, en = 1, one edge → out = 16'h0100. Load 16'h0999 → next edge gives 16'h1000.
- Wrap:
  - Default build: load 16'h9999 → tc = 1 and carry_out = 1 before the edge; after one en edge, out = 16'h0000 and ovf = 1. A following load of 16'h0005 clears ovf.
  - DECADE_UP_SAT_EN defined: at 16'h9999 with en, out stays 16'h9999, ovf = 1 and carry_out = 0.
- Illegal digit: load 16'h000C, en for one edge → out = 16'h0000, with no carry into digit 1.
- Priority and asynchronous reset:
  - load = 1 and en = 1 with load_val = 16'h4321 at tc → out = 16'h4321 and ovf = 0.
  - Assert reset between edges → out = 0 immediately, without waiting for a falling edge.

Source files
------------

// File: rtl/decade_pkg.sv
// Shared constants and helpers for the BCD decade counters.
package decade_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // True when a digit sits at the top of its decade (illegal codes excluded).
    function automatic logic is_bcd_max(input logic [BCD_W-1:0] digit);
        return (digit == BCD_MAX);
    endfunction

    // Next value of a stepping digit: 9 and any illegal code 10..15 fold to 0.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] digit);
        logic [BCD_W-1:0] nxt;
        if (digit >= BCD_MAX) begin
            nxt = BCD_ZERO;
        end else begin
            nxt = digit + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// One BCD decade cell of the up counter. Updates on the falling clock edge;
// load has priority over step. is9 flags a legal 9 for the carry chain.
module bcd_digit_up
    import decade_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_digit,
    output logic [BCD_W-1:0] digit,
    output logic             is9
);

    logic [BCD_W-1:0] digit_r;

    // Digit register: async clear, then load, then step, else hold.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            digit_r <= BCD_ZERO;
        end else if (load) begin
            digit_r <= ld_digit;
        end else if (step) begin
            digit_r <= bcd_inc(digit_r);
        end else begin
            digit_r <= digit_r;
        end
    end

    assign digit = digit_r;
    assign is9   = is_bcd_max(digit_r);

endmodule

// File: rtl/decade_counter_up.sv
// Multi-digit BCD decade up counter built from bcd_digit_up cells.
// Optional build macro: DECADE_UP_SAT_EN -- when defined the counter saturates
// at all-9s (out holds, ovf sets, carry_out stays low) instead of wrapping.
module decade_counter_up
    import decade_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   out,
    output logic                      tc,
    output logic                      carry_out,
    output logic                      ovf
);

    logic [DIGITS-1:0] is9_s;
    logic [DIGITS-1:0] low9_s;
    logic [DIGITS-1:0] step_s;
    logic              tc_s;
    logic              count_s;
    logic              ovf_r;

    // Prefix AND of the is9 flags: low9_s[k] is high when digits 0..k-1 are all 9.
    always_comb begin
        logic acc;
        acc    = 1'b1;
        low9_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            low9_s[k] = acc;
            acc       = acc & is9_s[k];
        end
        tc_s = acc;
    end

`ifdef DECADE_UP_SAT_EN
    // Saturating build: no digit moves once the whole counter reads all-9s.
    assign count_s = en & ~tc_s;
`else
    assign count_s = en;
`endif

    assign step_s = {DIGITS{count_s}} & low9_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_up u_digit (
                .clk      (clk),
                .reset    (reset),
                .step     (step_s[g]),
                .load     (load),
                .ld_digit (load_val[BCD_W*g +: BCD_W]),
                .digit    (out[BCD_W*g +: BCD_W]),
                .is9      (is9_s[g])
            );
        end
    endgenerate

    // Sticky overflow: cleared by reset or load, set by an enabled count at all-9s.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (load) begin
            ovf_r <= 1'b0;
        end else if (en && tc_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
    assign tc  = tc_s;

`ifdef DECADE_UP_SAT_EN
    assign carry_out = 1'b0;
`else
    assign carry_out = en & tc_s & ~load;
`endif

endmodule
